// File: rtl/pipeline_adder_arbiter_pkg.sv
// Shared widths and stage payload types for the round-robin pipelined adder.
package adder_arb_pkg;
    localparam int NREQ_DEF = 4;
    localparam int OP_W     = 8;
    localparam int NIB_W    = 4;
    localparam int STATS_W  = 16;

    typedef struct packed {
        logic [NIB_W-1:0] lo;
        logic             c4;
        logic [NIB_W-1:0] a_hi;
        logic [NIB_W-1:0] b_hi;
    } s1_dat_t;

    typedef struct packed {
        logic            cout;
        logic [OP_W-1:0] sum;
    } rsp_dat_t;
endpackage

// File: rtl/pipeline_adder_arbiter_if.sv
// Request/response bundle: NREQ packed requesters in, one valid/ready result stream out.
interface pipeline_adder_arbiter_if #(
    parameter int NREQ = adder_arb_pkg::NREQ_DEF,
    parameter int ID_W = $clog2(NREQ)
) ();
    import adder_arb_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [OP_W*NREQ-1:0] req_a;
    logic [OP_W*NREQ-1:0] req_b;
    logic [NREQ-1:0]      req_cin;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [OP_W-1:0]      rsp_sum;
    logic                 rsp_cout;
    logic                 busy;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/pipeline_adder_arbiter_pipe.sv
// Two-stage nibble-split 8-bit adder; 2-cycle latency, one op per cycle.
// i_hold freezes every stage (no bubble collapse).
module pipe_add8
    import adder_arb_pkg::*;
#(
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_hold,
    input  logic            i_vld,
    input  logic [OP_W-1:0] i_a,
    input  logic [OP_W-1:0] i_b,
    input  logic            i_cin,
    input  logic [ID_W-1:0] i_id,
    output logic            o_vld,
    output logic [ID_W-1:0] o_id,
    output logic [OP_W-1:0] o_sum,
    output logic            o_cout,
    output logic            o_busy
);
    logic            r_v1;
    logic [ID_W-1:0] r_id1;
    s1_dat_t         r_s1;
    logic            r_v2;
    logic [ID_W-1:0] r_id2;
    rsp_dat_t        r_rsp;

    logic [NIB_W:0]  w_lo;
    logic [NIB_W:0]  w_hi;

    assign w_lo = {1'b0, i_a[NIB_W-1:0]} + {1'b0, i_b[NIB_W-1:0]} + {{NIB_W{1'b0}}, i_cin};
    assign w_hi = {1'b0, r_s1.a_hi} + {1'b0, r_s1.b_hi} + {{NIB_W{1'b0}}, r_s1.c4};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v1  <= 1'b0;
            r_id1 <= '0;
            r_s1  <= '0;
            r_v2  <= 1'b0;
            r_id2 <= '0;
            r_rsp <= '0;
        end else if (!i_hold) begin
            r_v1       <= i_vld;
            r_id1      <= i_id;
            r_s1.lo    <= w_lo[NIB_W-1:0];
            r_s1.c4    <= w_lo[NIB_W];
            r_s1.a_hi  <= i_a[OP_W-1:NIB_W];
            r_s1.b_hi  <= i_b[OP_W-1:NIB_W];
            r_v2       <= r_v1;
            r_id2      <= r_id1;
            r_rsp.cout <= w_hi[NIB_W];
            r_rsp.sum  <= {w_hi[NIB_W-1:0], r_s1.lo};
        end
    end

    assign o_vld  = r_v2;
    assign o_id   = r_id2;
    assign o_sum  = r_rsp.sum;
    assign o_cout = r_rsp.cout;
    assign o_busy = r_v1 | r_v2;
endmodule

// File: rtl/pipeline_adder_arbiter.sv
// Round-robin arbiter feeding a 2-cycle adder pipe; result 2 edges after grant, 1 op/cycle.
// Backpressure: rsp_valid && !rsp_ready stalls the whole pipe and withholds all grants. Option: ADDER_ARB_STATS_EN adds op_count.
module pipeline_adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                      enable,
    input  logic                      rst,
    pipeline_adder_arbiter_if.slave   bus
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]        op_count
`endif
);
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_gnt_id;
    logic [ID_W-1:0] w_ptr_nxt;
    logic [NREQ-1:0] w_grant;
    logic            w_found;
    logic            w_stall;
    logic            w_go;
    logic            w_accept;
    logic [OP_W-1:0] w_a;
    logic [OP_W-1:0] w_b;
    logic            w_cin;
    logic            w_pipe_vld;

    // Search begins at r_ptr and wraps; grant depends only on req_valid.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'((int'(r_ptr) + k) % NREQ);
            end
        end
        w_grant           = '0;
        w_grant[w_gnt_id] = w_found;
    end

    assign w_stall   = bus.rsp_valid & ~bus.rsp_ready;
    assign w_go      = rst & ~w_stall;
    assign w_accept  = w_found & w_go;
    assign w_ptr_nxt = (int'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + 1'b1;

    assign bus.req_ready = w_grant & {NREQ{w_go}};

    assign w_a   = bus.req_a[int'(w_gnt_id)*OP_W +: OP_W];
    assign w_b   = bus.req_b[int'(w_gnt_id)*OP_W +: OP_W];
    assign w_cin = bus.req_cin[w_gnt_id];

    always_ff @(posedge enable) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    pipe_add8 #(
        .ID_W (ID_W)
    ) u_pipe (
        .clk    (enable),
        .rst    (rst),
        .i_hold (w_stall),
        .i_vld  (w_accept),
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (w_cin),
        .i_id   (w_gnt_id),
        .o_vld  (w_pipe_vld),
        .o_id   (bus.rsp_id),
        .o_sum  (bus.rsp_sum),
        .o_cout (bus.rsp_cout),
        .o_busy (bus.busy)
    );

    // Gated so a result never appears during reset, even before the clearing edge.
    assign bus.rsp_valid = w_pipe_vld & rst;

`ifdef ADDER_ARB_STATS_EN
    logic [STATS_W-1:0] r_op_count;

    always_ff @(posedge enable) begin
        if (!rst) begin
            r_op_count <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign op_count = r_op_count;
`endif
endmodule
